// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate-lab checkers.
// Holds the checker FSM state type, the number of stimulus vectors and
// the expected-value functions of the gates under test. Sibling checkers
// (AND, XOR, NOR) add their own expected_* functions here.
package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 4;

    function automatic logic expected_or(input logic a, input logic b);
        return a | b;
    endfunction

endpackage

// File: rtl/or_gate_checker_if.sv
// Signal bundle between the OR-gate checker and the gate lab it drives.
//   start     : run request (level, sampled each cycle)
//   z         : gate-under-test output
//   a, b      : registered drive to the gate inputs
//   busy      : run in progress
//   done      : run finished, results valid
//   pass      : done with no mismatching vector
//   err_cnt   : number of mismatching vectors
//   fail_mask : bit i set when vector {a,b} = i mismatched
// master = checker side, slave = gate/controller side.
interface or_gate_checker_if;
    import gate_check_pkg::*;

    logic                   start;
    logic                   z;
    logic                   a;
    logic                   b;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [2:0]             err_cnt;
    logic [NUM_VECTORS-1:0] fail_mask;

    modport master (
        input  start, z,
        output a, b, busy, done, pass, err_cnt, fail_mask
    );

    modport slave (
        output start, z,
        input  a, b, busy, done, pass, err_cnt, fail_mask
    );

endinterface

// File: rtl/or_gate_checker_settle_timer.sv
// Loadable settle down-counter.
//   clk, rst_n : clock, async active-low reset
//   load       : load SETTLE_CYCLES-1 (wins over en)
//   en         : decrement by one
//   zero       : counter at terminal count
// The caller only enables the count while zero is low, so it never wraps.
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CNT_W'(SETTLE_CYCLES - 1);
        end else if (en) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/or_gate_checker.sv
// Self-checking stimulus stage for the two-input OR-from-NAND gate.
// On start it walks {a,b} = 00, 01, 10, 11, holds each for SETTLE_CYCLES
// cycles, then samples z against the expected OR and accumulates results.
//   clk, rst_n : clock, async active-low reset
//   bus        : or_gate_checker_if.master (start/z in, drive and results out)
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | after reset, waiting for start
//   SETTLE | vector driven, waiting for the settle timer to reach zero
//   CHECK  | compare z with expected_or(a,b), advance or finish
//   DONE   | results held, {a,b}=11; start launches a fresh run
module or_gate_checker
    import gate_check_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    or_gate_checker_if.master  bus
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_VECTORS - 1);

    state_t                 state_q;
    state_t                 state_nxt;
    logic [1:0]             idx_q;
    logic                   a_q;
    logic                   b_q;
    logic [2:0]             err_cnt_q;
    logic [NUM_VECTORS-1:0] fail_mask_q;

    logic tmr_load;
    logic tmr_en;
    logic tmr_zero;
    logic start_run;
    logic check_en;
    logic mismatch;

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .en    (tmr_en),
        .zero  (tmr_zero)
    );

    // Compare against the registered drive, which is exactly what the gate sees.
    assign mismatch = (bus.z != expected_or(a_q, b_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        start_run = 1'b0;
        check_en  = 1'b0;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    start_run = 1'b1;
                    tmr_load  = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (tmr_zero) begin
                    state_nxt = CHECK;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            CHECK: begin
                check_en = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_nxt = DONE;
                end else begin
                    tmr_load  = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            err_cnt_q   <= '0;
            fail_mask_q <= '0;
        end else if (start_run) begin
            idx_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            err_cnt_q   <= '0;
            fail_mask_q <= '0;
        end else if (check_en) begin
            if (mismatch) begin
                err_cnt_q          <= err_cnt_q + 3'd1;
                fail_mask_q[idx_q] <= 1'b1;
            end
            if (idx_q != LAST_IDX) begin
                idx_q      <= idx_q + 2'd1;
                {a_q, b_q} <= idx_q + 2'd1;
            end
        end
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.busy      = (state_q == SETTLE) || (state_q == CHECK);
    assign bus.done      = (state_q == DONE);
    assign bus.pass      = (state_q == DONE) && (err_cnt_q == '0);
    assign bus.err_cnt   = err_cnt_q;
    assign bus.fail_mask = fail_mask_q;

endmodule

// File: tb/tb_or_gate_checker.sv
// Bench for or_gate_checker: two instances (SETTLE_CYCLES 4 and 1), each
// driving a gate model with a programmable truth table and 0..3 cycle delay.
module tb_or_gate_checker;

    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    or_gate_checker_if bus4 ();
    or_gate_checker_if bus1 ();

    or_gate_checker #(.SETTLE_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    or_gate_checker #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance stimulus and gate model controls.
    logic       start_v [2];
    logic [3:0] lut_v   [2];
    int         dly_v   [2];
    logic [1:0] prev_ab [2];
    logic [1:0] hist0   [3];
    logic [1:0] hist1   [3];
    logic       z_v     [2];

    logic       o_a    [2];
    logic       o_b    [2];
    logic       o_busy [2];
    logic       o_done [2];
    logic       o_pass [2];
    logic [2:0] o_err  [2];
    logic [3:0] o_mask [2];

    assign bus4.start = start_v[0];
    assign bus1.start = start_v[1];
    assign bus4.z     = z_v[0];
    assign bus1.z     = z_v[1];

    assign o_a[0] = bus4.a;       assign o_a[1] = bus1.a;
    assign o_b[0] = bus4.b;       assign o_b[1] = bus1.b;
    assign o_busy[0] = bus4.busy; assign o_busy[1] = bus1.busy;
    assign o_done[0] = bus4.done; assign o_done[1] = bus1.done;
    assign o_pass[0] = bus4.pass; assign o_pass[1] = bus1.pass;
    assign o_err[0]  = bus4.err_cnt;   assign o_err[1]  = bus1.err_cnt;
    assign o_mask[0] = bus4.fail_mask; assign o_mask[1] = bus1.fail_mask;

    // Gate model: z after edge k = lut[{a,b} after edge k-dly].
    always @(posedge clk) begin
        hist0[0] <= {bus4.a, bus4.b};
        hist0[1] <= hist0[0];
        hist0[2] <= hist0[1];
        hist1[0] <= {bus1.a, bus1.b};
        hist1[1] <= hist1[0];
        hist1[2] <= hist1[1];
    end

    always_comb begin
        z_v[0] = (dly_v[0] == 0) ? lut_v[0][{bus4.a, bus4.b}] : lut_v[0][hist0[dly_v[0]-1]];
        z_v[1] = (dly_v[1] == 0) ? lut_v[1][{bus1.a, bus1.b}] : lut_v[1][hist1[dly_v[1]-1]];
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: vector i is sampled at edge (i+1)*(s+1) after the start edge
    // and sees the gate responding to the drive present dly edges earlier.
    function automatic void model(input int s, input logic [3:0] lut, input int dly,
                                  input logic [1:0] prev,
                                  output logic [2:0] err, output logic [3:0] mask);
        err  = 3'd0;
        mask = 4'd0;
        for (int i = 0; i < 4; i++) begin
            int         c;
            int         k;
            logic [1:0] src;
            logic       want;
            c    = (i + 1) * (s + 1);
            k    = c - 1 - dly;
            src  = (k >= 0) ? 2'(k / (s + 1)) : prev;
            want = (i[1] == 1'b1) || (i[0] == 1'b1);
            if (lut[src] != want) begin
                err     = err + 3'd1;
                mask[i] = 1'b1;
            end
        end
    endfunction

    task automatic check_results(input string tag, input int d, input logic [2:0] e_err,
                                 input logic [3:0] e_mask);
        check({tag, "_done"}, 8'(o_done[d]), 8'd1);
        check({tag, "_busy"}, 8'(o_busy[d]), 8'd0);
        check({tag, "_ab"},   8'({o_a[d], o_b[d]}), 8'd3);
        check({tag, "_err"},  8'(o_err[d]), 8'(e_err));
        check({tag, "_mask"}, 8'(o_mask[d]), 8'(e_mask));
        check({tag, "_pass"}, 8'(o_pass[d]), 8'(e_err == 3'd0));
    endtask

    task automatic run(input string tag, input int d, input logic [3:0] lut, input int dly,
                       input bit timeline, input bit hold);
        int         s;
        int         n;
        logic [2:0] e_err;
        logic [3:0] e_mask;
        s = (d == 0) ? 4 : 1;
        n = 4 * (s + 1);
        @(negedge clk);
        lut_v[d] = lut;
        dly_v[d] = dly;
        repeat (4) @(negedge clk);
        model(s, lut, dly, prev_ab[d], e_err, e_mask);
        start_v[d] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start_v[d] = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (timeline) begin
                check({tag, "_tl_ab"},   8'({o_a[d], o_b[d]}), 8'(k / (s + 1)));
                check({tag, "_tl_busy"}, 8'(o_busy[d]), 8'd1);
                check({tag, "_tl_done"}, 8'(o_done[d]), 8'd0);
            end
            @(posedge clk);
            #1;
        end
        check_results(tag, d, e_err, e_mask);
        prev_ab[d] = 2'd3;
        if (hold) begin
            @(posedge clk);
            #1;
            check({tag, "_rs_busy"}, 8'(o_busy[d]), 8'd1);
            check({tag, "_rs_done"}, 8'(o_done[d]), 8'd0);
            check({tag, "_rs_err"},  8'(o_err[d]), 8'd0);
            check({tag, "_rs_mask"}, 8'(o_mask[d]), 8'd0);
            check({tag, "_rs_ab"},   8'({o_a[d], o_b[d]}), 8'd0);
            start_v[d] = 1'b0;
            model(s, lut, dly, 2'd3, e_err, e_mask);
            repeat (n) @(posedge clk);
            #1;
            check_results({tag, "_r2"}, d, e_err, e_mask);
        end
    endtask

    initial begin
        logic [2:0] e_err;
        logic [3:0] e_mask;
        rst_n      = 1'b0;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        lut_v[0]   = 4'b1110;
        lut_v[1]   = 4'b1110;
        dly_v[0]   = 0;
        dly_v[1]   = 0;
        prev_ab[0] = 2'd0;
        prev_ab[1] = 2'd0;
        #12;
        for (int d = 0; d < 2; d++) begin
            check("rst_ab",   8'({o_a[d], o_b[d]}), 8'd0);
            check("rst_busy", 8'(o_busy[d]), 8'd0);
            check("rst_done", 8'(o_done[d]), 8'd0);
            check("rst_pass", 8'(o_pass[d]), 8'd0);
            check("rst_err",  8'(o_err[d]), 8'd0);
            check("rst_mask", 8'(o_mask[d]), 8'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        run("ideal",    0, 4'b1110, 0, 1'b1, 1'b0);
        run("stuck0",   0, 4'b0000, 0, 1'b0, 1'b0);
        check("stuck0_spec_mask", 8'(o_mask[0]), 8'b1110);
        run("and",      0, 4'b1000, 0, 1'b0, 1'b0);
        check("and_spec_mask", 8'(o_mask[0]), 8'b0110);
        run("dly3_s4",  0, 4'b1110, 3, 1'b0, 1'b0);
        check("dly3_s4_pass", 8'(o_pass[0]), 8'd1);
        run("dly3_s1",  1, 4'b1110, 3, 1'b1, 1'b0);
        check("dly3_s1_nz", 8'(o_mask[1] != 4'd0), 8'd1);

        // Reset during SETTLE of vector 2, after vector 1 already failed.
        @(negedge clk);
        lut_v[0] = 4'b1000;
        dly_v[0] = 0;
        repeat (4) @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("mid_err_before", 8'(o_err[0]), 8'd1);
        check("mid_ab_before",  8'({o_a[0], o_b[0]}), 8'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_ab",   8'({o_a[0], o_b[0]}), 8'd0);
        check("mid_busy", 8'(o_busy[0]), 8'd0);
        check("mid_done", 8'(o_done[0]), 8'd0);
        check("mid_pass", 8'(o_pass[0]), 8'd0);
        check("mid_err",  8'(o_err[0]), 8'd0);
        check("mid_mask", 8'(o_mask[0]), 8'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        prev_ab[0] = 2'd0;
        prev_ab[1] = 2'd0;
        run("post_rst", 0, 4'b1110, 0, 1'b1, 1'b0);

        // start held through a failing run, restart from DONE.
        run("hold", 0, 4'b1000, 0, 1'b1, 1'b1);

        // Randomized truth tables and delays on both instances.
        for (int r = 0; r < 8; r++) begin
            run("rand_s4", 0, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b0, 1'b0);
            run("rand_s1", 1, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end

        // Sanity of the reference against known answers.
        model(4, 4'b0000, 0, 2'd0, e_err, e_mask);
        check("model_vs_dut_stuck0", 8'(e_mask), 8'b1110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/or_gate_checker.md
# or_gate_checker

Self-checking stimulus stage that sits directly upstream of the two-input OR-from-NAND gate and drives its `A`/`B` inputs. On a start pulse it walks the four input combinations 00, 01, 10, 11. For each one it waits a programmable settle time, samples the gate output `Z` and compares it with the expected OR value. It reports an error count, a per-vector fail mask and a pass/done status, which lets the gate lab be checked in hardware as well as in simulation.

## Interface
- `SETTLE_CYCLES`, default 4: clock cycles each vector is held before `z` is sampled; legal range is 1 or more.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: level sampled each cycle; acted on only in IDLE or DONE.
- `z` input 1: output of the gate under test.
- `a` output 1: registered drive to gate input A.
- `b` output 1: registered drive to gate input B.
- `busy` output 1: high in SETTLE and CHECK.
- `done` output 1: high in DONE.
- `pass` output 1: high in DONE when `err_cnt == 0`; low otherwise.
- `err_cnt` output 3: number of mismatching vectors, 0..4.
- `fail_mask` output 4: bit i set if vector i ({a,b} = i) mismatched.

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- Reset values: state IDLE; `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_mask`=0; vector index=0; settle counter=0.
- **IDLE + start:**
  - vector index <= 0; {a,b} <= 2'b00.
  - Clear `err_cnt` and `fail_mask`.
  - Settle counter <= SETTLE_CYCLES-1.
  - Go to SETTLE.
- **SETTLE:** decrement the counter. When the counter is 0, go to CHECK. `a`/`b` are held stable.
- **CHECK:**
  - Sample `z` and compute expected = a | b.
  - On mismatch: `err_cnt` += 1 and `fail_mask[index]` <= 1.
  - If index == 3, go to DONE.
  - Otherwise: index += 1, drive {a,b} = index+1, reload the counter with SETTLE_CYCLES-1, go to SETTLE.
- **DONE:**
  - `a`/`b` hold 2'b11; results are held.
  - `start` restarts exactly as from IDLE, with results cleared in the same edge.
  - DONE never returns to IDLE except by reset.
- `start` is ignored in SETTLE and CHECK.
- Comparison uses only the registered `a`/`b` values, never a re-derived index.
- Arithmetic widths:
  - Settle counter width is $clog2(SETTLE_CYCLES+1).
  - `err_cnt` cannot exceed 4, so it is 3 bits with no saturation needed.
  - Vector index is 2 bits; incrementing past 3 never occurs.

## Timing
- Let t0 be the edge at which `start` is accepted.
  - `busy` rises after t0.
  - The first {a,b} = 00 appears after t0.
- Each vector occupies SETTLE_CYCLES cycles in SETTLE plus 1 cycle in CHECK.
- `z` is sampled at the edge leaving CHECK, i.e. SETTLE_CYCLES+1 edges after the vector was driven.
- `done` and `pass` rise at edge t0 + 4*(SETTLE_CYCLES+1); `busy` falls at the same edge.
- The mismatch update for the last vector is visible in the same cycle that `done` rises.
- Reset mid-run: asynchronous return to the reset values above. No partial results survive.
- `z` is treated as synchronous to `clk`: the gate is driven only by this block's registers, and the settle time covers the gate propagation delay.

## Structure
- Shared package `gate_check_pkg`:
  - `state_t` enum {IDLE, SETTLE, CHECK, DONE}.
  - `localparam NUM_VECTORS = 4`.
  - Function `expected_or(a,b)`. Sibling checkers for AND, XOR and NOR add their own expected functions here.
- One natural sub-module, `settle_timer`:
  - Loadable down-counter parameterised by SETTLE_CYCLES.
  - Inputs: `load`, `en`. Output: `zero`.
- The top level contains only the FSM, vector/drive registers and result registers.

## Test plan
- **Ideal OR model, SETTLE_CYCLES=4, start pulse at t0:**
  - {a,b} sequence is 00, 01, 10, 11, each held 5 cycles.
  - `done`=1 at t0+20 with `pass`=1, `err_cnt`=0, `fail_mask`=4'b0000.
- **`z` stuck at 0:** `err_cnt`=3, `fail_mask`=4'b1110, `pass`=0.
- **Gate model replaced by AND:** `err_cnt`=2, `fail_mask`=4'b0110, `pass`=0.
- **Gate with 3-cycle output delay, SETTLE_CYCLES=4:** `pass`=1.
- **Gate with 3-cycle output delay, SETTLE_CYCLES=1:** `fail_mask` is nonzero.
- **`rst_n` pulsed low during SETTLE of vector 2:** all outputs are 0 immediately, state is IDLE, and a later start yields the full clean run.
- **`start` held high through a whole run, then from DONE after a failing run:**
  - No restart while `busy`.
  - In DONE, `start` clears `err_cnt` and `fail_mask` at the next edge and begins again at {a,b}=00.
